// File: rtl/shift_rows_pipe.sv
// ----------------------------------------------------------------------------
// shift_rows_pipe
// AES/Rijndael ShiftRows / InvShiftRows / bypass stage with a 2-entry output
// FIFO. The transform is applied to the incoming block and the result is stored.
// The FIFO head is a register that drives out_data directly, so a block that is
// accepted into an empty FIFO is presented on the same clock edge.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream block present on in_data / in_inv / in_byp
//   in_ready   : FIFO has room (occupancy < 2). Registered, and independent
//                of out_ready.
//   in_data    : input state, byte k at in_data[W-1-8k -: 8], column-major
//   in_inv     : 1 = InvShiftRows, 0 = ShiftRows
//   in_byp     : 1 = pass in_data unchanged. This overrides in_inv.
//   out_valid  : out_data holds a transformed block
//   out_ready  : downstream accepts out_data this cycle
//   out_data   : transformed state (FIFO head register)
// ----------------------------------------------------------------------------
module shift_rows_pipe #(
    parameter int unsigned NB = 4,
    parameter int unsigned W  = 32 * NB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_inv,
    input  logic         in_byp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Reject an unsupported block size at elaboration time.
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (W != 32 * NB) begin : g_bad_w
        $error("shift_rows_pipe: W must equal 32*NB");
    end

    // Row rotation amount. Rijndael-256 uses 1,3,4 for rows 1..3.
    function automatic int unsigned row_off(input int unsigned r);
        if (r == 0) return 0;
        if (NB == 8) return (r == 1) ? 1 : ((r == 2) ? 3 : 4);
        return r;
    endfunction

    logic [W-1:0] w_fwd;
    logic [W-1:0] w_inv;
    logic [W-1:0] w_xf;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count_nxt;

    logic [1:0]   r_count;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         r_out_valid;
    logic         r_in_ready;

    // Byte permutations. Pure wiring, because every source index is a constant.
    for (genvar gr = 0; gr < 4; gr++) begin : g_row
        for (genvar gc = 0; gc < int'(NB); gc++) begin : g_col
            localparam int unsigned R   = gr;
            localparam int unsigned C   = gc;
            localparam int unsigned OFF = row_off(R);
            localparam int unsigned SF  = (C + OFF) % NB;
            localparam int unsigned SI  = (C + NB - OFF) % NB;
            localparam int unsigned DB  = W - 1 - 8 * (4 * C + R);
            localparam int unsigned FB  = W - 1 - 8 * (4 * SF + R);
            localparam int unsigned IB  = W - 1 - 8 * (4 * SI + R);
            assign w_fwd[DB -: 8] = in_data[FB -: 8];
            assign w_inv[DB -: 8] = in_data[IB -: 8];
        end
    end

    // Mode select. Bypass wins over inverse.
    always_comb begin
        w_xf = w_fwd;
        if (in_byp)      w_xf = in_data;
        else if (in_inv) w_xf = w_inv;
    end

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;

    // Next occupancy. A push is never seen at occupancy 2 because in_ready is low.
    always_comb begin
        w_count_nxt = r_count;
        case (r_count)
            2'd0:    w_count_nxt = w_push ? 2'd1 : 2'd0;
            2'd1: begin
                if (w_push && !w_pop)      w_count_nxt = 2'd2;
                else if (!w_push && w_pop) w_count_nxt = 2'd0;
            end
            2'd2:    w_count_nxt = w_pop ? 2'd1 : 2'd2;
            default: w_count_nxt = 2'd0;
        endcase
    end

    // FIFO storage: r_head is always the oldest block, and r_tail the second one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 2'd0;
            r_head      <= '0;
            r_tail      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != 2'd0);
            r_in_ready  <= (w_count_nxt != 2'd2);
            case (r_count)
                2'd0: if (w_push) r_head <= w_xf;
                2'd1: begin
                    if (w_push && w_pop) r_head <= w_xf;
                    else if (w_push)     r_tail <= w_xf;
                end
                2'd2: if (w_pop) r_head <= r_tail;
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// ----------------------------------------------------------------------------
// tb_shift_rows_pipe
// Testbench for shift_rows_pipe. It runs an NB=4 instance and an NB=8 instance,
// checks table vectors, and runs directed sequences for backpressure, stream
// throughput and reset.
// ----------------------------------------------------------------------------
module tb_shift_rows_pipe;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         in_valid, in_ready, in_inv, in_byp, out_valid, out_ready;
    logic [127:0] in_data, out_data;

    logic         d8_in_valid, d8_in_ready, d8_in_inv, d8_in_byp;
    logic         d8_out_valid, d8_out_ready;
    logic [255:0] d8_in_data, d8_out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .in_byp(in_byp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    shift_rows_pipe #(.NB(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_data(d8_in_data),
        .in_inv(d8_in_inv), .in_byp(d8_in_byp),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready), .out_data(d8_out_data)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int off_of(input int nb, input int r);
        if (r == 0) return 0;
        if (nb == 8) return (r == 1) ? 1 : ((r == 2) ? 3 : 4);
        return r;
    endfunction

    // Reference model in scatter form. Each source byte is moved to its destination column.
    function automatic logic [255:0] ref_xf(input int nb, input logic [255:0] d,
                                            input bit inv, input bit byp);
        logic [255:0] o;
        int w, dst;
        o = '0;
        w = 32 * nb;
        if (byp) return d;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                if (inv) dst = (c + off_of(nb, r)) % nb;
                else     dst = (c + nb - off_of(nb, r)) % nb;
                o[w-1-8*(4*dst+r) -: 8] = d[w-1-8*(4*c+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        string        name;
        logic [127:0] din;
        bit           inv;
        bit           byp;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs[6];
    logic [127:0] exp_q[$];
    logic [127:0] blk_a, blk_b, blk_c, blk_e, exp3[3];
    logic [255:0] seq8, r8;
    int           idx, sent, got, first_cyc, last_cyc;
    bit           pend, m_inv, m_byp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"aes_fwd",  128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b0,
                                128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vecs[1] = '{"aes_inv",  128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 1'b0,
                                128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[2] = '{"aes_byp",  128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b1,
                                128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[3] = '{"seq_fwd",  128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0,
                                128'h00050a0f04090e03080d02070c01060b};
        vecs[4] = '{"seq_inv",  128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0,
                                128'h000d0a0704010e0b0805020f0c090603};
        vecs[5] = '{"byp_ovr",  128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b1,
                                128'h000102030405060708090a0b0c0d0e0f};

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_byp = 1'b0; out_ready = 1'b1;
        d8_in_valid = 1'b0; d8_in_data = '0; d8_in_inv = 1'b0; d8_in_byp = 1'b0;
        d8_out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_out_data",  256'(out_data),  256'(0));
        chk("rst_in_ready",  256'(in_ready),  256'(1'b1));
        chk("rst8_out_valid", 256'(d8_out_valid), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, with the FIFO empty and out_ready=1
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk({vecs[i].name, "_idle_valid"}, 256'(out_valid), 256'(1'b0));
            in_valid = 1'b1; in_data = vecs[i].din; in_inv = vecs[i].inv; in_byp = vecs[i].byp;
            chk({vecs[i].name, "_in_ready"}, 256'(in_ready), 256'(1'b1));
            @(negedge clk);
            in_valid = 1'b0;
            chk({vecs[i].name, "_valid"}, 256'(out_valid), 256'(1'b1));
            chk({vecs[i].name, "_data"},  256'(out_data),  256'(vecs[i].exp));
        end

        // NB=8 forward on bytes 0x00..0x1f, then inverse of that result
        for (int k = 0; k < 32; k++) seq8[255-8*k -: 8] = 8'(k);
        @(negedge clk);
        d8_in_valid = 1'b1; d8_in_data = seq8; d8_in_inv = 1'b0;
        @(negedge clk);
        d8_in_valid = 1'b0;
        r8 = d8_out_data;
        chk("nb8_fwd_valid", 256'(d8_out_valid), 256'(1'b1));
        chk("nb8_r3c0", 256'(r8[255-8*3 -: 8]), 256'(8'h13));
        chk("nb8_r2c0", 256'(r8[255-8*2 -: 8]), 256'(8'h0e));
        chk("nb8_fwd_all", r8, ref_xf(8, seq8, 1'b0, 1'b0));
        @(negedge clk);
        d8_in_valid = 1'b1; d8_in_data = r8; d8_in_inv = 1'b1;
        @(negedge clk);
        d8_in_valid = 1'b0;
        chk("nb8_inv_restore", d8_out_data, seq8);

        // Backpressure: three blocks with out_ready=0, then drain in order
        blk_a = rnd128(); blk_b = rnd128(); blk_c = rnd128();
        exp3[0] = ref_xf(4, blk_a, 1'b0, 1'b0)[127:0];
        exp3[1] = ref_xf(4, blk_b, 1'b1, 1'b0)[127:0];
        exp3[2] = blk_c;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = blk_a; in_inv = 1'b0; in_byp = 1'b0;
        @(negedge clk);
        in_data = blk_b; in_inv = 1'b1;
        chk("bp_a_head", 256'(out_data), 256'(exp3[0]));
        chk("bp_in_ready_1", 256'(in_ready), 256'(1'b1));
        @(negedge clk);
        in_data = blk_c; in_inv = 1'b0; in_byp = 1'b1;
        chk("bp_full_in_ready", 256'(in_ready), 256'(1'b0));
        @(negedge clk);
        chk("bp_held_in_ready", 256'(in_ready), 256'(1'b0));
        chk("bp_stable_data", 256'(out_data), 256'(exp3[0]));
        chk("bp_stable_valid", 256'(out_valid), 256'(1'b1));
        idx = 0; pend = 1'b1;
        for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
            if (cyc != 0) @(negedge clk);
            in_valid = pend; out_ready = 1'b1;
            if (out_valid) begin
                chk($sformatf("bp_drain_%0d", idx), 256'(out_data), 256'(exp3[idx]));
                idx++;
            end
            if (in_valid && in_ready) pend = 1'b0;
        end
        chk("bp_drain_count", 256'(idx), 256'(3));
        @(negedge clk);
        in_valid = 1'b0; in_byp = 1'b0;

        // Mode pins toggled without a transfer must not change the held block
        @(negedge clk);
        chk("idle_pop_empty", 256'(out_valid), 256'(1'b0));
        out_ready = 1'b0; in_valid = 1'b1; in_data = blk_a; in_inv = 1'b0; in_byp = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_inv = 1'b1; in_byp = 1'b1;
        @(negedge clk);
        in_inv = 1'b0;
        @(negedge clk);
        chk("mode_noxfer_data", 256'(out_data), 256'(exp3[0]));
        out_ready = 1'b1;
        @(negedge clk);
        in_byp = 1'b0;
        chk("mode_noxfer_drained", 256'(out_valid), 256'(1'b0));

        // Full-rate stream: 100 random blocks with random modes, out_ready held 1
        sent = 0; got = 0; first_cyc = -1; last_cyc = -1;
        exp_q.delete();
        for (int cyc = 0; cyc < 120 && got < 100; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected_out", 256'(out_valid), 256'(1'b0));
                end else begin
                    chk($sformatf("stream_%0d", got), 256'(out_data), 256'(exp_q.pop_front()));
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            in_valid = (sent < 100);
            if (in_valid) begin
                in_data = rnd128();
                m_byp = ($urandom_range(0, 2) == 2);
                m_inv = 1'($urandom_range(0, 1));
                in_inv = m_inv; in_byp = m_byp;
                chk("stream_in_ready", 256'(in_ready), 256'(1'b1));
                if (in_ready) begin
                    exp_q.push_back(ref_xf(4, 256'(in_data), m_inv, m_byp)[127:0]);
                    sent++;
                end
            end
        end
        chk("stream_count", 256'(got), 256'(100));
        chk("stream_one_per_cycle", 256'(last_cyc - first_cyc), 256'(99));
        in_valid = 1'b0;

        // Asynchronous reset while the FIFO is full
        blk_e = rnd128();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = blk_b; in_inv = 1'b0; in_byp = 1'b0;
        @(negedge clk);
        in_data = blk_c;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mid_full", 256'(in_ready), 256'(1'b0));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_mid_out_data",  256'(out_data),  256'(0));
        chk("rst_mid_in_ready",  256'(in_ready),  256'(1'b1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_data = blk_e; in_inv = 1'b1; in_byp = 1'b0;
        chk("rst_rel_in_ready", 256'(in_ready), 256'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_first_valid", 256'(out_valid), 256'(1'b1));
        chk("rst_first_data", 256'(out_data), ref_xf(4, 256'(blk_e), 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_stale_%0d", i), 256'(out_valid), 256'(1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 Parameter NB, default 4: state width in 32-bit columns; legal values 4, 6, 8.
REQ-002 Parameter W, default 32*NB: data width in bits; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 in_valid  input  1  upstream block present on in_data/in_inv/in_byp.
REQ-006 in_ready  output  1  block can accept a transfer this cycle.
REQ-007 in_data  input  W  input state.
REQ-008 in_inv  input  1  1 = InvShiftRows, 0 = ShiftRows; sampled with the transfer.
REQ-009 in_byp  input  1  1 = pass data unchanged; overrides in_inv.
REQ-010 out_valid  output  1  transformed block present on out_data.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  W  transformed state.

Function
REQ-013 Byte k occupies in_data[W-1-8k -: 8]; byte k is row r = k mod 4, column c = k div 4 (column-major, byte 0 at MSB).
REQ-014 Row offsets: row 0 = 0; rows 1,2,3 = 1,2,3 for NB 4 and 6; rows 1,2,3 = 1,3,4 for NB 8.
REQ-015 Forward: out(r,c) = in(r, (c + off_r) mod NB).
REQ-016 Inverse: out(r,c) = in(r, (c - off_r) mod NB), with non-negative modulo result.
REQ-017 Bypass: out_data = in_data bit-exact.
REQ-018 NB outside {4,6,8} is an elaboration-time error; no silent default.
REQ-019 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-020 Transform is applied on the input side; a 2-entry FIFO stores transformed blocks.
REQ-021 Latency: a block accepted at edge N is on out_data with out_valid=1 from edge N onward when the FIFO was empty (one-cycle latency, registered output).
REQ-022 in_ready = (occupancy < 2), driven from registered occupancy only; no combinational path from out_ready to in_ready.
REQ-023 Full throughput: with out_ready held 1, one block per cycle is accepted and delivered.
REQ-024 Occupancy 1, simultaneous push and pop: occupancy stays 1, new block becomes head on the next edge.
REQ-025 Occupancy 2: in_ready=0; any in_valid is ignored and no data is lost or overwritten.
REQ-026 Occupancy 0 with out_ready=1: no pop, out_valid stays 0.
REQ-027 Order preserved; mode bits apply per block, so forward, inverse and bypass blocks interleave freely.
REQ-028 out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-029 in_inv/in_byp changes without a transfer have no effect.

Reset
REQ-030 rst_n low asynchronously clears occupancy to 0, read/write pointers to 0, out_valid to 0 and out_data to all zeros.
REQ-031 in_ready = 1 after reset (occupancy 0).
REQ-032 Reset mid-operation discards all stored blocks; no partial block is ever presented afterwards.
REQ-033 First transfer is possible at the first rising edge after rst_n deasserts.

Verification
REQ-034 NB=4, forward, in_data=0xd42711aee0bf98f1b8b45de51e415230 -> out_data=0xd4bf5d30e0b452aeb84111f11e2798e5, one cycle later.
REQ-035 NB=4, inverse, in_data=0xd4bf5d30e0b452aeb84111f11e2798e5 -> out_data=0xd42711aee0bf98f1b8b45de51e415230; bypass returns the input unchanged.
REQ-036 NB=8, forward, bytes 0x00..0x1F in order -> byte at (r=3,c=0) is 0x13 and byte at (r=2,c=0) is 0x0E; inverse of that result restores 0x00..0x1F.
REQ-037 out_ready=0, push 3 blocks -> in_ready low after 2 accepted, third held; release out_ready -> blocks 1,2,3 out in order, no drop.
REQ-038 Continuous in_valid/out_ready=1 for 100 random blocks with random modes -> 100 outputs, one per cycle, all matching the reference model.
REQ-039 Assert rst_n low while occupancy=2 -> out_valid=0, out_data=0, in_ready=1 immediately; no stale block appears after release.
